// File: rtl/tx_ilas_gen_if.sv
// ============================================================================
// Module      : tx_ilas_gen_if
// Description : Control and octet-stream bundle between the link controller
//               (master) and the ILAS generator (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tx_ilas_gen_if;
    logic         i_start;
    logic         i_abort;
    logic [7:0]   i_f;
    logic [4:0]   i_k;
    logic [111:0] i_cfg;
    logic [7:0]   o_data;
    logic         o_vld;
    logic         o_k;
    logic         o_busy;
    logic         o_done;
    logic         o_cfg_err;

    modport master (
        output i_start, i_abort, i_f, i_k, i_cfg,
        input  o_data, o_vld, o_k, o_busy, o_done, o_cfg_err
    );

    modport slave (
        input  i_start, i_abort, i_f, i_k, i_cfg,
        output o_data, o_vld, o_k, o_busy, o_done, o_cfg_err
    );
endinterface

`default_nettype wire

// File: rtl/tx_ilas_gen.sv
// ============================================================================
// Module      : tx_ilas_gen
// Description : JESD204B ILAS octet generator for one lane. Optional macro
//               TX_ILAS_FCHK_EN replaces config octet 13 with the FCHK sum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_ilas_gen #(
    parameter int NUM_MF     = 4,
    parameter int CFG_OCTETS = 14
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    tx_ilas_gen_if.slave    bus
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;
    localparam int         c_CFGW    = CFG_OCTETS * 8;
    localparam logic [3:0] c_MF_LAST = 4'(NUM_MF - 1);

    logic [0:0]        r_state, w_state_nxt;
    logic [12:0]       r_oct, w_oct_nxt;
    logic [3:0]        r_mf, w_mf_nxt;
    logic [12:0]       r_lm1;
    logic [c_CFGW-1:0] r_cfg;
    logic [7:0]        r_data, w_data;
    logic              r_vld, r_k, r_busy, r_done, r_cfg_err;
    logic              w_vld, w_k, w_busy, w_done, w_cfg_err;
    logic [12:0]       w_lm1_in;
    logic [c_CFGW-1:0] w_cfg_cap;
    logic [3:0]        w_cfg_idx;
    logic              w_start_req, w_short, w_mf_end, w_last;

    // L-1 = F*K + F + K with F,K the minus-one encodings; never exceeds 8191
    assign w_lm1_in    = 13'(bus.i_f) * 13'(bus.i_k) + 13'(bus.i_f) + 13'(bus.i_k);
    assign w_short     = (w_lm1_in < 13'd16);
    assign w_start_req = (r_state == c_ST_IDLE) && bus.i_start && !bus.i_abort;
    assign w_mf_end    = (r_oct == r_lm1);
    assign w_last      = w_mf_end && (r_mf == c_MF_LAST);

`ifdef TX_ILAS_FCHK_EN
    function automatic logic [7:0] fchk_sum(input logic [c_CFGW-1:0] cfg);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < CFG_OCTETS - 1; i++) s = s + cfg[i*8 +: 8];
        return s;
    endfunction

    assign w_cfg_cap = {fchk_sum(bus.i_cfg), bus.i_cfg[c_CFGW-9:0]};
`else
    assign w_cfg_cap = bus.i_cfg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_start_req && !w_short)  w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (bus.i_abort || w_last)    w_state_nxt = c_ST_IDLE;
            default:                                 w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Outputs are computed for the position that will be presented after the edge
    always_comb begin
        w_oct_nxt = '0;
        w_mf_nxt  = '0;
        w_vld     = 1'b0;
        w_busy    = 1'b0;
        w_k       = 1'b0;
        w_data    = '0;
        w_done    = 1'b0;
        w_cfg_err = w_start_req && w_short;
        w_cfg_idx = w_oct_nxt[3:0] - 4'd2;
        if (w_state_nxt == c_ST_RUN) begin
            if (r_state == c_ST_RUN) begin
                if (w_mf_end) begin
                    w_mf_nxt = r_mf + 4'd1;
                end else begin
                    w_oct_nxt = r_oct + 13'd1;
                    w_mf_nxt  = r_mf;
                end
            end
            w_cfg_idx = w_oct_nxt[3:0] - 4'd2;
            w_vld     = 1'b1;
            w_busy    = 1'b1;
            w_done    = (w_oct_nxt == r_lm1) && (w_mf_nxt == c_MF_LAST);
            if (w_oct_nxt == 13'd0) begin
                w_k    = 1'b1;
                w_data = 8'h1C;
            end else if (w_oct_nxt == r_lm1) begin
                w_k    = 1'b1;
                w_data = 8'h7C;
            end else if (w_mf_nxt == 4'd1 && w_oct_nxt == 13'd1) begin
                w_k    = 1'b1;
                w_data = 8'h9C;
            end else if (w_mf_nxt == 4'd1 && w_oct_nxt >= 13'd2 && w_oct_nxt <= 13'd15) begin
                w_data = r_cfg[{w_cfg_idx, 3'b000} +: 8];
            end else begin
                w_data = w_oct_nxt[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oct     <= '0;
            r_mf      <= '0;
            r_lm1     <= '0;
            r_cfg     <= '0;
            r_data    <= '0;
            r_vld     <= 1'b0;
            r_k       <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_oct     <= w_oct_nxt;
            r_mf      <= w_mf_nxt;
            r_data    <= w_data;
            r_vld     <= w_vld;
            r_k       <= w_k;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_cfg_err <= w_cfg_err;
            if (w_start_req && !w_short) begin
                r_lm1 <= w_lm1_in;
                r_cfg <= w_cfg_cap;
            end
        end
    end

    assign bus.o_data    = r_data;
    assign bus.o_vld     = r_vld;
    assign bus.o_k       = r_k;
    assign bus.o_busy    = r_busy;
    assign bus.o_done    = r_done;
    assign bus.o_cfg_err = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_tx_ilas_gen.sv
// ============================================================================
// Module      : tb_tx_ilas_gen
// Description : Self-checking bench for tx_ilas_gen (vector table plus
//               abort, back-to-back and asynchronous-reset sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_ilas_gen;

    localparam int NUM_MF = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tx_ilas_gen_if bus();

    tx_ilas_gen #(.NUM_MF(NUM_MF), .CFG_OCTETS(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0]   f;
        logic [4:0]   k;
        logic [111:0] cfg;
        bit           err;
        int           total;
        int           probe;
        logic [7:0]   pval;
    } vec_t;

    vec_t vt[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // {cfg_err, vld, busy, k, done, data}
    function automatic logic [12:0] dut_w();
        return {bus.o_cfg_err, bus.o_vld, bus.o_busy, bus.o_k, bus.o_done, bus.o_data};
    endfunction

    function automatic logic [111:0] mk_cfg(input logic [7:0] base, input logic [7:0] inc,
                                            input logic [7:0] oct13);
        logic [111:0] c;
        logic [7:0]   v;
        c = '0;
        v = base;
        for (int i = 0; i < 13; i++) begin
            c[i*8 +: 8] = v;
            v = v + inc;
        end
        c[111:104] = oct13;
        return c;
    endfunction

    function automatic logic [12:0] exp_word(input int o, input int m, input int L,
                                             input logic [111:0] cfg, input bit last);
        logic [7:0] d;
        logic       k;
        logic [7:0] s;
        k = 1'b0;
        d = 8'(o);
        if (o == 0) begin
            k = 1'b1; d = 8'h1C;
        end else if (o == L - 1) begin
            k = 1'b1; d = 8'h7C;
        end else if (m == 1 && o == 1) begin
            k = 1'b1; d = 8'h9C;
        end else if (m == 1 && o >= 2 && o <= 15) begin
            d = cfg[(o-2)*8 +: 8];
`ifdef TX_ILAS_FCHK_EN
            if (o == 15) begin
                s = '0;
                for (int i = 0; i < 13; i++) s = s + cfg[i*8 +: 8];
                d = s;
            end
`endif
        end
        return {1'b0, 1'b1, 1'b1, k, last, d};
    endfunction

    task automatic run_vec(input string nm, input vec_t v, input bit poke);
        int L;
        bus.i_f     = v.f;
        bus.i_k     = v.k;
        bus.i_cfg   = v.cfg;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        // captured copies must be used from here on
        bus.i_f     = ~v.f;
        bus.i_k     = ~v.k;
        bus.i_cfg   = ~v.cfg;
        if (v.err) begin
            chk({nm, " cfg_err pulse"}, 32'(dut_w()), 32'h1000);
            step();
            chk({nm, " cfg_err clear"}, 32'(dut_w()), 32'h0);
            return;
        end
        L = v.total / NUM_MF;
        for (int cyc = 0; cyc < v.total; cyc++) begin
            if (cyc > 0) step();
            chk($sformatf("%s cyc%0d", nm, cyc), 32'(dut_w()),
                32'(exp_word(cyc % L, cyc / L, L, v.cfg, cyc == v.total - 1)));
            if (cyc == v.probe) chk({nm, " probe"}, 32'(bus.o_data), 32'(v.pval));
            bus.i_start = poke && (cyc == 10 || cyc == v.total - 1);
        end
        step();
        bus.i_start = 1'b0;
        chk({nm, " idle after"}, 32'(dut_w()), 32'h0);
    endtask

    initial begin
        logic [111:0] cfg_a;
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_f     = '0;
        bus.i_k     = '0;
        bus.i_cfg   = '0;

        cfg_a = mk_cfg(8'h10, 8'h01, 8'h1D);
        vt[0] = '{8'd0,  5'd31, cfg_a,                           1'b0, 128,  48,  8'h10};
        vt[1] = '{8'd0,  5'd15, cfg_a,                           1'b1, 0,    -1,  8'h00};
        vt[2] = '{8'd0,  5'd16, mk_cfg(8'h40, 8'h01, 8'h4D),     1'b0, 68,   33,  8'h7C};
        vt[3] = '{8'd3,  5'd3,  cfg_a,                           1'b1, 0,    -1,  8'h00};
        vt[4] = '{8'd1,  5'd8,  mk_cfg(8'hA0, 8'h03, 8'h55),     1'b0, 72,   19,  8'h9C};
        vt[5] = '{8'd20, 5'd15, cfg_a,                           1'b0, 1344, 972, 8'h2C};
`ifdef TX_ILAS_FCHK_EN
        vt[6] = '{8'd0,  5'd16, mk_cfg(8'h14, 8'h00, 8'hAB),     1'b0, 68,   32,  8'h04};
`else
        vt[6] = '{8'd0,  5'd16, mk_cfg(8'h14, 8'h00, 8'hAB),     1'b0, 68,   32,  8'hAB};
`endif
        vt[7] = '{8'd0,  5'd0,  cfg_a,                           1'b1, 0,    -1,  8'h00};

        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", 32'(dut_w()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle after reset", 32'(dut_w()), 32'h0);

        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vt[i], 1'b0);

        // starts at cycle 10 and on the done cycle are ignored; next cycle restarts
        run_vec("busy_start", vt[0], 1'b1);
        bus.i_f     = 8'd0;
        bus.i_k     = 5'd31;
        bus.i_cfg   = cfg_a;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk("b2b restart R", 32'(dut_w()), 32'h0E1C);
        step();
        chk("b2b ramp", 32'(dut_w()), 32'h0C01);
        bus.i_abort = 1'b1;
        step();
        bus.i_abort = 1'b0;
        chk("b2b abort", 32'(dut_w()), 32'h0);

        // abort after 40 valid cycles of an L=32 run
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) step();
            chk($sformatf("abort_run cyc%0d", cyc), 32'(dut_w()),
                32'(exp_word(cyc % 32, cyc / 32, 32, cfg_a, 1'b0)));
        end
        bus.i_abort = 1'b1;
        bus.i_start = 1'b1;
        step();
        bus.i_abort = 1'b0;
        bus.i_start = 1'b0;
        chk("abort clears", 32'(dut_w()), 32'h0);
        for (int j = 0; j < 3; j++) begin
            step();
            chk("abort stays idle", 32'(dut_w()), 32'h0);
        end
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk("restart R", 32'(dut_w()), 32'h0E1C);
        step();
        chk("restart ramp", 32'(dut_w()), 32'h0C01);

        // asynchronous reset mid-sequence
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset", 32'(dut_w()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post reset idle", 32'(dut_w()), 32'h0);
        step();
        chk("post reset idle2", 32'(dut_w()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
